// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add / restoring division)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_res, neg_rem, special;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic              a_sgn, b_sgn, sa, sb, div0, ovf, special_in;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res;
  logic [XLEN:0]     mul_sum, shifted, trial;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;
  always_comb begin
    a_sgn      = op_i[2] ? ~op_i[0] : (op_i != 3'b011);
    b_sgn      = op_i[2] ? ~op_i[0] : ~op_i[1];
    sa         = a_sgn & a_i[XLEN-1];
    sb         = b_sgn & b_i[XLEN-1];
    mag_a      = sa ? -a_i : a_i;
    mag_b      = sb ? -b_i : b_i;
    div0       = (b_i == '0);
    ovf        = ~op_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
    special_in = op_i[2] & (div0 | ovf);
    spec_res   = div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted    = {rem[XLEN-1:0], acc[XLEN-1]};
    trial      = shifted - {1'b0, opnd};
    div_ge     = ~trial[XLEN];
    prod       = neg_res ? -acc : acc;
    quo        = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd        = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    fix_res    = special ? acc[XLEN-1:0] :
                 op_q[2] ? (op_q[1] ? rmd : quo) :
                 (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    stall_o    = (valid_i & (state == IDLE)) | (state == CALC) | (state == FIX);
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
  end
  // special cases park their final result in acc and skip CALC entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      special  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          op_q    <= op_i;
          opnd    <= op_i[2] ? mag_b : mag_a;
          acc     <= {{XLEN{1'b0}}, special_in ? spec_res : (op_i[2] ? mag_a : mag_b)};
          rem     <= '0;
          neg_res <= sa ^ sb;
          neg_rem <= sa;
          special <= special_in;
          cnt     <= '0;
          state   <= special_in ? FIX : CALC;
        end
        CALC: begin
          acc   <= op_q[2] ? {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge} : {mul_sum, acc[XLEN-1:1]};
          rem   <= op_q[2] ? (div_ge ? trial : shifted) : rem;
          cnt   <= cnt + 5'd1;
          state <= (cnt == 5'd31) ? FIX : CALC;
        end
        FIX: begin
          result_o <= fix_res;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        clk = 0;
  logic        rst, valid_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          op;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          errs = 0;
  logic [31:0] last_res = '0;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic is_special(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, za, sb, zb, p;
    int ia, ib;
    logic ovf;
    sa = {{32{a[31]}}, a};
    za = {32'b0, a};
    sb = {{32{b[31]}}, b};
    zb = {32'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; return ia / ib; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return 0; return ia % ib; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  // monitor: sampled 1 time unit after the falling edge so driver updates have settled
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (done_o) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_done result=%h cycle=%0d", result_o, cyc);
        end else begin
          e = q.pop_front();
          if (result_o !== e.res || cyc != e.cyc || stall_o !== 1'b0) begin
            errs++;
            $display("FAIL op%0d_result got=%h exp=%h cycle=%0d exp_cycle=%0d stall=%b", e.op, result_o, e.res, cyc, e.cyc, stall_o);
          end
          last_res = e.res;
        end
      end else begin
        checks++;
        if (result_o !== last_res) begin
          errs++;
          $display("FAIL result_hold got=%h exp=%h cycle=%0d", result_o, last_res, cyc);
        end
      end
    end
  end
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    valid_i = 1;
    op_i = op;
    a_i = a;
    b_i = b;
    q.push_back('{model(op, a, b), cyc + (is_special(op, a, b) ? 2 : 34), int'(op)});
    #1 chk("stall_accept", {31'b0, stall_o}, 32'd1);
  endtask
  task automatic follow(logic sp);
    int n;
    logic ok;
    n = sp ? 1 : 33;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      valid_i = (k == 5);
      if (k == 5) begin
        op_i = 3'($urandom_range(0, 7));
        a_i = $urandom;
        b_i = $urandom;
      end
      #1 chk("stall_busy", {30'b0, stall_o, busy_o}, 32'd3);
    end
    ok = 0;
    for (int k = 0; k < 6 && !ok; k++) begin
      @(negedge clk);
      valid_i = 0;
      #2;
      ok = (q.size() == 0);
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL done_timeout pending=%0d cycle=%0d", q.size(), cyc);
      q.delete();
    end
  endtask
  task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    issue(op, a, b);
    follow(is_special(op, a, b));
  endtask
  logic [2:0]  d_op[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
  logic [31:0] d_a[14]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[14]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
  logic [31:0] pick[5]  = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  initial begin
    rst = 1;
    valid_i = 0;
    flush_i = 0;
    op_i = 0;
    a_i = 0;
    b_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i], d_b[i]);
    // flush a DIV in cycle 10, then accept a MUL in cycle 11
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      valid_i = 0;
    end
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    void'(q.pop_back());
    #1;
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_result", result_o, last_res);
    issue(3'd0, 32'd3, 32'd4);
    follow(1'b0);
    // reset in cycle 20 of a MUL
    @(negedge clk);
    issue(3'd0, 32'd9, 32'd9);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid_i = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    last_res = '0;
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      run_op(3'($urandom_range(0, 7)), a, b);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
